// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb native master bridge. One transaction in flight;
// every output comes from a register, so there is no combinational path from wb to iob.
module iob_wishbone2iob #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    output logic [2:0]          dbg_state_o
);

    // Handshakes: Wishbone side completes a cycle with a single-cycle wb_ack_o or
    // wb_err_o while cyc&stb are high; IOb side transfers a request on the cycle
    // where iob_avalid_o and iob_ready_i are both 1, and read data on iob_rvalid_i.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        RDWAIT = 3'd2,
        ACK    = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam int CNT_W = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    // Counter value whose increment reaches 2^TIMEOUT_W-1 and fires the timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = ~CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               we_q;
    logic               avalid_d, ack_d, err_d, latch_en;
    logic [DATA_W-1:0]  dat_d;
    logic               wb_active;
    logic               timeout_hit;

    assign wb_active   = wb_cyc_i & wb_stb_i;
    assign timeout_hit = (TIMEOUT_W > 0) && (cnt_q == CNT_LAST);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        avalid_d = iob_avalid_o;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = wb_dat_o;
        latch_en = 1'b0;
        if ((state_q == REQ || state_q == RDWAIT) && !wb_cyc_i) begin
            abort_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                dat_d = '0;
                // The cycle carrying the previous ack/err still has stb high; skip it.
                if (wb_active && !wb_ack_o && !wb_err_o) begin
                    latch_en = 1'b1;
                    avalid_d = 1'b1;
                    cnt_d    = '0;
                    abort_d  = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    state_d  = we_q ? ACK : RDWAIT;
                end else if (timeout_hit) begin
                    avalid_d = 1'b0;
                    state_d  = ERR;
                end
            end
            RDWAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (iob_rvalid_i) begin
                    dat_d   = iob_rdata_i;
                    state_d = ACK;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            ACK: begin
                ack_d = wb_active & ~abort_q;
                if (!ack_d) begin
                    dat_d = '0;
                end
                state_d = IDLE;
            end
            ERR: begin
                err_d   = wb_active & ~abort_q;
                dat_d   = '0;
                state_d = IDLE;
            end
            default: begin
                avalid_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            we_q         <= 1'b0;
            wb_dat_o     <= '0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            iob_avalid_o <= 1'b0;
            iob_addr_o   <= '0;
            iob_wdata_o  <= '0;
            iob_wstrb_o  <= '0;
        end else if (cke_i) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            wb_dat_o     <= dat_d;
            wb_ack_o     <= ack_d;
            wb_err_o     <= err_d;
            iob_avalid_o <= avalid_d;
            if (latch_en) begin
                we_q        <= wb_we_i;
                iob_addr_o  <= wb_adr_i;
                iob_wdata_o <= wb_dat_i;
                iob_wstrb_o <= wb_we_i ? wb_sel_i : '0;
            end
        end
    end

endmodule
